// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA sequencer: streams words from src to dst through an external
// show-ahead FIFO, with read credits bounding the data in flight.
module dma_xfer_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  byte_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_req,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_gnt,
  input  logic                  rd_rvalid,
  input  logic [DATA_WIDTH-1:0] rd_rdata,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_gnt,
  output logic                  fifo_push,
  output logic [DATA_WIDTH-1:0] fifo_push_data,
  input  logic                  fifo_full,
  output logic                  fifo_pop,
  input  logic [DATA_WIDTH-1:0] fifo_pop_data,
  input  logic                  fifo_empty,
  output logic [1:0]            dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int WW = LEN_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [WW-1:0]         rd_left;
  logic [WW-1:0]         wr_left;
  logic [CW-1:0]         credit;
  logic [CW-1:0]         outstanding;
  logic                  in_run;
  logic                  rd_fire;
  logic                  wr_fire;
  logic                  rsp_ok;
  logic                  unused_bits;

  assign unused_bits = ^{src_addr[1:0], dst_addr[1:0], byte_len[1:0]};

  // Handshakes: a request holds with stable address/data until its grant; a transfer
  // happens on the cycle req && gnt are both high. Responses carry no back-pressure.
  assign in_run  = (state == RUN);
  assign rd_req  = in_run && (rd_left != '0) && (credit != '0);
  assign rd_addr = rd_ptr;
  assign rd_fire = rd_req && rd_gnt;

  assign wr_req   = in_run && !fifo_empty && (wr_left != '0);
  assign wr_addr  = wr_ptr;
  assign wr_data  = wr_req ? fifo_pop_data : '0;
  assign fifo_pop = wr_req && wr_gnt;
  assign wr_fire  = fifo_pop;

  assign fifo_push      = rd_rvalid;
  assign fifo_push_data = rd_rvalid ? rd_rdata : '0;

  assign rsp_ok    = (outstanding != '0);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      rd_left     <= '0;
      wr_left     <= '0;
      credit      <= '0;
      outstanding <= '0;
    end else begin
      // A response with nothing outstanding, or into a full FIFO, is a protocol error.
      if (rd_rvalid && (fifo_full || !rsp_ok)) err <= 1'b1;

      if (rd_fire && !(rd_rvalid && rsp_ok))      outstanding <= outstanding + CW'(1);
      else if (!rd_fire && rd_rvalid && rsp_ok)   outstanding <= outstanding - CW'(1);

      case (state)
        IDLE: begin
          if (start) begin
            rd_ptr  <= {src_addr[ADDR_WIDTH-1:2], 2'b00};
            wr_ptr  <= {dst_addr[ADDR_WIDTH-1:2], 2'b00};
            rd_left <= byte_len[LEN_WIDTH-1:2];
            wr_left <= byte_len[LEN_WIDTH-1:2];
            credit  <= CW'(FIFO_DEPTH);
            err     <= 1'b0;
            if (byte_len[LEN_WIDTH-1:2] == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_fire) begin
            rd_ptr  <= rd_ptr + ADDR_WIDTH'(4);
            rd_left <= rd_left - WW'(1);
          end
          if (wr_fire) begin
            wr_ptr  <= wr_ptr + ADDR_WIDTH'(4);
            wr_left <= wr_left - WW'(1);
          end
          if (rd_fire && !wr_fire)      credit <= credit - CW'(1);
          else if (wr_fire && !rd_fire) credit <= credit + CW'(1);
          if (wr_fire && (wr_left == WW'(1))) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed bench for dma_xfer_ctrl with a 2-cycle-latency memory responder,
// a 16-entry show-ahead FIFO model and a write capture monitor.
module tb_dma_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] src_addr, dst_addr;
  logic [15:0] byte_len;
  logic        busy, done, err;
  logic        rd_req, rd_gnt, rd_rvalid;
  logic [31:0] rd_addr, rd_rdata;
  logic        wr_req, wr_gnt;
  logic [31:0] wr_addr, wr_data;
  logic        fifo_push, fifo_pop;
  logic [31:0] fifo_push_data;
  logic        fifo_full = 1'b0;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_pop_data = '0;
  logic [1:0]  dbg_state;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dma_xfer_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(16), .LEN_WIDTH(16)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .byte_len(byte_len),
    .busy(busy), .done(done), .err(err),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_rvalid(rd_rvalid), .rd_rdata(rd_rdata),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .fifo_push(fifo_push), .fifo_push_data(fifo_push_data), .fifo_full(fifo_full),
    .fifo_pop(fifo_pop), .fifo_pop_data(fifo_pop_data), .fifo_empty(fifo_empty),
    .dbg_state(dbg_state)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C3C_A5A5;
  endfunction

  // memory responder: data returns two cycles after the read grant
  logic        s1_v, s2_v;
  logic [31:0] s1_d, s2_d;
  logic        inj_v;
  logic [31:0] inj_d;

  always @(posedge clk) begin
    if (!rstn) begin
      s1_v <= 1'b0; s2_v <= 1'b0; s1_d <= '0; s2_d <= '0;
    end else begin
      s1_v <= rd_req && rd_gnt;
      s1_d <= mem_word(rd_addr);
      s2_v <= s1_v;
      s2_d <= s1_d;
    end
  end

  assign rd_rvalid = s2_v | inj_v;
  assign rd_rdata  = inj_v ? inj_d : (s2_v ? s2_d : 32'h0);

  // show-ahead FIFO model
  logic [31:0] fq[$];
  always @(posedge clk) begin
    if (!rstn) fq.delete();
    else begin
      if (fifo_pop && fq.size() > 0) void'(fq.pop_front());
      if (fifo_push && fq.size() < 16) fq.push_back(fifo_push_data);
    end
    fifo_empty    <= (fq.size() == 0);
    fifo_full     <= (fq.size() >= 16);
    fifo_pop_data <= (fq.size() > 0) ? fq[0] : 32'h0;
  end

  // capture monitor
  logic        clr;
  logic [31:0] ra_q[$];
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int done_cnt, busy_cnt, req_cnt, push_full_cnt, inflight, max_inflight;

  always @(posedge clk) begin
    if (clr) begin
      ra_q.delete(); wa_q.delete(); wd_q.delete();
      done_cnt = 0; busy_cnt = 0; req_cnt = 0; push_full_cnt = 0;
      inflight = 0; max_inflight = 0;
    end else begin
      if (rd_req && rd_gnt) ra_q.push_back(rd_addr);
      if (wr_req && wr_gnt) begin
        wa_q.push_back(wr_addr);
        wd_q.push_back(wr_data);
      end
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      if (rd_req || wr_req) req_cnt++;
      if (fifo_push && fifo_full) push_full_cnt++;
      inflight = inflight + int'(rd_req && rd_gnt) - int'(wr_req && wr_gnt);
      if (inflight > max_inflight) max_inflight = inflight;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    src_addr = s; dst_addr = d; byte_len = l;
    start = 1'b1; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'b0, done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; byte_len = '0;
    rd_gnt = 1'b1; wr_gnt = 1'b1; inj_v = 1'b0; inj_d = '0; clr = 1'b1;
    repeat (3) @(negedge clk);
    clr = 1'b0;

    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_rd_req", {31'b0, rd_req}, 0);
    check("rst_wr_req", {31'b0, wr_req}, 0);
    check("rst_push", {31'b0, fifo_push}, 0);
    check("rst_pop", {31'b0, fifo_pop}, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_state", {30'b0, dbg_state}, 0);
    rstn = 1'b1;
    @(negedge clk);

    // basic 16-byte copy
    kick(32'h1000, 32'h2000, 16'd16);
    check("basic_busy", {31'b0, busy}, 1);
    check("basic_rd_req", {31'b0, rd_req}, 1);
    wait_done("basic_done");
    check("basic_busy_at_done", {31'b0, busy}, 0);
    check("basic_err", {31'b0, err}, 0);
    @(negedge clk);
    check("basic_done_low", {31'b0, done}, 0);
    check("basic_idle", {30'b0, dbg_state}, 0);
    check("basic_nrd", ra_q.size(), 4);
    check("basic_nwr", wa_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("basic_rd_addr", ra_q[i], 32'h1000 + 32'(4 * i));
      check("basic_wr_addr", wa_q[i], 32'h2000 + 32'(4 * i));
      check("basic_wr_data", wd_q[i], mem_word(32'h1000 + 32'(4 * i)));
    end
    check("basic_done_cnt", done_cnt, 1);

    // backpressure: 32 words, writes stalled
    wr_gnt = 1'b0;
    kick(32'h4000, 32'h8000, 16'd128);
    repeat (40) @(negedge clk);
    #1;
    check("bp_rd_req_low", {31'b0, rd_req}, 0);
    check("bp_nrd_stall", ra_q.size(), 16);
    check("bp_fifo_full", {31'b0, fifo_full}, 1);
    check("bp_wr_req", {31'b0, wr_req}, 1);
    wr_gnt = 1'b1;
    wait_done("bp_done");
    @(negedge clk);
    check("bp_nrd", ra_q.size(), 32);
    check("bp_nwr", wa_q.size(), 32);
    for (int i = 0; i < 32; i++) begin
      check("bp_wr_addr", wa_q[i], 32'h8000 + 32'(4 * i));
      check("bp_wr_data", wd_q[i], mem_word(32'h4000 + 32'(4 * i)));
    end
    check("bp_max_inflight", max_inflight, 16);
    check("bp_push_full", push_full_cnt, 0);
    check("bp_err", {31'b0, err}, 0);

    // zero length: word count 0
    kick(32'h100, 32'h200, 16'h0003);
    check("zero_done", {31'b0, done}, 1);
    check("zero_busy", {31'b0, busy}, 0);
    @(negedge clk);
    check("zero_done_low", {31'b0, done}, 0);
    check("zero_idle", {30'b0, dbg_state}, 0);
    repeat (3) @(negedge clk);
    check("zero_req_cnt", req_cnt, 0);
    check("zero_busy_cnt", busy_cnt, 0);
    check("zero_done_cnt", done_cnt, 1);

    // address wrap, with ignored low address bits on dst
    kick(32'hFFFF_FFF8, 32'h0000_0503, 16'd16);
    wait_done("wrap_done");
    @(negedge clk);
    check("wrap_rd0", ra_q[0], 32'hFFFF_FFF8);
    check("wrap_rd1", ra_q[1], 32'hFFFF_FFFC);
    check("wrap_rd2", ra_q[2], 32'h0000_0000);
    check("wrap_rd3", ra_q[3], 32'h0000_0004);
    check("wrap_wr0", wa_q[0], 32'h0000_0500);
    check("wrap_wr3", wa_q[3], 32'h0000_050C);
    check("wrap_data2", wd_q[2], mem_word(32'h0000_0000));

    // protocol error: response with nothing outstanding
    rd_gnt = 1'b0;
    kick(32'h6000, 32'h7000, 16'd16);
    check("err_before", {31'b0, err}, 0);
    inj_d = 32'hBAD0_BAD0; inj_v = 1'b1;
    #1;
    check("err_push_comb", {31'b0, fifo_push}, 1);
    check("err_push_data", fifo_push_data, 32'hBAD0_BAD0);
    @(negedge clk);
    inj_v = 1'b0;
    #1;
    check("err_set", {31'b0, err}, 1);
    rd_gnt = 1'b1;
    wait_done("err_done");
    check("err_held_done", {31'b0, err}, 1);
    @(negedge clk);
    check("err_held_idle", {31'b0, err}, 1);
    kick(32'h6000, 32'h7000, 16'd4);
    check("err_cleared", {31'b0, err}, 0);
    check("err_clear_busy", {31'b0, busy}, 1);
    wait_done("err_clear_done");
    repeat (4) @(negedge clk);

    // reset mid-transfer
    kick(32'hC000, 32'hD000, 16'd128);
    for (int i = 0; i < 200 && wa_q.size() < 5; i++) @(negedge clk);
    check("rst_mid_reached", {31'b0, wa_q.size() >= 5}, 1);
    rstn = 1'b0;
    @(negedge clk);
    check("rstm_busy", {31'b0, busy}, 0);
    check("rstm_done", {31'b0, done}, 0);
    check("rstm_rd_req", {31'b0, rd_req}, 0);
    check("rstm_wr_req", {31'b0, wr_req}, 0);
    check("rstm_push", {31'b0, fifo_push}, 0);
    check("rstm_pop", {31'b0, fifo_pop}, 0);
    check("rstm_rd_addr", rd_addr, 0);
    check("rstm_wr_addr", wr_addr, 0);
    check("rstm_state", {30'b0, dbg_state}, 0);
    rstn = 1'b1;
    @(negedge clk);
    kick(32'h9000, 32'hA000, 16'd8);
    wait_done("post_rst_done");
    @(negedge clk);
    check("post_rst_nwr", wa_q.size(), 2);
    check("post_rst_wa0", wa_q[0], 32'hA000);
    check("post_rst_wa1", wa_q[1], 32'hA004);
    check("post_rst_wd0", wd_q[0], mem_word(32'h9000));
    check("post_rst_wd1", wd_q[1], mem_word(32'h9004));
    check("post_rst_err", {31'b0, err}, 0);
    check("post_rst_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_xfer_ctrl.md
# dma_xfer_ctrl

Sequencing controller for one DMA channel: copies a word-aligned block from a source address to a destination address, staging data through the channel FIFO. It drives the FIFO push side from memory read responses and the FIFO pop side into memory writes. It runs reads and writes concurrently and uses a credit counter so that read data can never overflow the FIFO. It sits between the DMA register block (start/length/addresses) and the memory interface.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; must equal FIFO data width
- FIFO_DEPTH, 16, FIFO entries; power of two, ≥2
- LEN_WIDTH, 16, byte-length field width

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low; clock clk
- start  in  1  one-cycle pulse; sampled only in IDLE
- src_addr  in  ADDR_WIDTH  source byte address; bits [1:0] ignored
- dst_addr  in  ADDR_WIDTH  destination byte address; bits [1:0] ignored
- byte_len  in  LEN_WIDTH  transfer length in bytes; bits [1:0] ignored
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- err  out  1  sticky protocol error; cleared by next accepted start
- rd_req  out  1  memory read request
- rd_addr  out  ADDR_WIDTH  read word address (byte units)
- rd_gnt  in  1  read request accepted this cycle
- rd_rvalid  in  1  read data valid; in order, one word per cycle
- rd_rdata  in  DATA_WIDTH  read data
- wr_req  out  1  memory write request
- wr_addr  out  ADDR_WIDTH  write address
- wr_data  out  DATA_WIDTH  write data
- wr_gnt  in  1  write accepted this cycle
- fifo_push  out  1  FIFO push
- fifo_push_data  out  DATA_WIDTH  FIFO push data
- fifo_full  in  1  FIFO full
- fifo_pop  out  1  FIFO pop
- fifo_pop_data  in  DATA_WIDTH  FIFO head word, valid while !fifo_empty (show-ahead)
- fifo_empty  in  1  FIFO empty

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE + start:
  - Latch rd_ptr = {src_addr[ADDR_WIDTH-1:2],2'b00} and wr_ptr = {dst_addr[ADDR_WIDTH-1:2],2'b00}.
  - Set rd_left = wr_left = byte_len[LEN_WIDTH-1:2] and credit = FIFO_DEPTH.
  - Clear err.
  - Go to RUN; if the word count is 0, go to DONE instead.
- RUN, read side:
  - rd_req = (rd_left≠0) && (credit≠0). rd_addr = rd_ptr.
  - On rd_req&&rd_gnt: rd_ptr += 4 (modulo 2^ADDR_WIDTH), rd_left −1, credit −1.
- RUN, fill:
  - fifo_push = rd_rvalid. fifo_push_data = rd_rdata. This path is combinational.
  - Each response is pushed regardless of state.
- RUN, write side:
  - wr_req = !fifo_empty && wr_left≠0.
  - wr_addr = wr_ptr. wr_data = fifo_pop_data.
  - fifo_pop = wr_req && wr_gnt.
  - On pop: wr_ptr += 4, wr_left −1, credit +1.
- Credit update on the same cycle as a grant and a pop: net 0. Credit width is log2(FIFO_DEPTH)+1. Credit never exceeds FIFO_DEPTH and never goes below 0.
- RUN → DONE when wr_left becomes 0 (the cycle of the final pop).
- DONE → IDLE unconditionally after one cycle.
- Error conditions (set err, sticky):
  - rd_rvalid && fifo_full.
  - rd_rvalid while the outstanding count (FIFO_DEPTH − credit − FIFO occupancy) would go negative. Tracked as: responses received > grants issued.
  - Data on an erroneous cycle is still pushed.
- start outside IDLE is ignored. Config inputs are only sampled at the accepted start.

## Timing
- Reset values: state IDLE, busy 0, done 0, err 0, rd_req 0, wr_req 0, fifo_push 0, fifo_pop 0. All address/data outputs 0; all counters 0.
- start accepted at cycle T:
  - busy = 1 from T+1.
  - rd_req may assert at T+1.
- busy is high in RUN only. done is high in DONE only.
- Final write handshake at cycle W: done = 1 and busy = 0 at W+1. A new start is accepted at W+2.
- Zero-length transfer: start at T → done at T+1. No rd_req or wr_req is issued.
- Handshakes:
  - rd_req/wr_req stay high, with address and data stable, until granted.
  - Back-to-back grants give one word per cycle on each side.
- Read-to-write latency is one FIFO cycle: a word pushed at cycle P can be popped at P+1 at the earliest.
- rstn low mid-transfer: all state returns to reset values on the next edge. Outstanding reads are abandoned. The FIFO is reset by the same rstn.

## Test plan
- Basic copy, 16 bytes, src 0x1000, dst 0x2000, grants always high, rvalid 2 cycles after grant:
  - Reads at 0x1000–0x100C, writes at 0x2000–0x200C, data preserved.
  - done exactly once; err = 0.
- Backpressure, 128 bytes (32 words), FIFO_DEPTH 16, wr_gnt held low for 40 cycles:
  - At most 16 read grants outstanding + buffered.
  - fifo_push never occurs while fifo_full; rd_req drops at credit 0.
  - All 32 words are written after wr_gnt resumes.
- Zero length (byte_len 0x0003): done pulse one cycle after start; no requests; busy never high.
- Address wrap, src 0xFFFF_FFF8, 16 bytes: read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Protocol error, rd_rvalid injected with no outstanding read: err = 1 and held through done. The next start clears it.
- Reset mid-transfer, rstn low at word 5 of 32:
  - All outputs return to reset values the next cycle.
  - A new 8-byte transfer then completes correctly.
